// File: rtl/mnk_game_pkg.sv
// Shared constants for the m,n,k game engine: cell codes, FSM states and the
// four scan directions as row/column deltas.
package mnk_game_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_CPU    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_SCAN,
    S_DONE
  } state_e;

  // Wide enough for origin (0..15) plus any offset (-15..15).
  typedef logic signed [7:0] coord_t;

  // Direction 0 = row, 1 = column, 2 = diagonal, 3 = anti-diagonal.
  function automatic coord_t dir_dr(input logic [1:0] d);
    case (d)
      2'd0:    dir_dr = 8'sd0;
      2'd3:    dir_dr = -8'sd1;
      default: dir_dr = 8'sd1;
    endcase
  endfunction

  function automatic coord_t dir_dc(input logic [1:0] d);
    dir_dc = (d == 2'd1) ? 8'sd0 : 8'sd1;
  endfunction

endpackage

// File: rtl/mnk_line_scanner.sv
// Walks the four lines through the last placed cell, one probe per cycle,
// tracking the current run of the mover's mark and latching any win.
module mnk_line_scanner
  import mnk_game_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       clear_i,
  input  logic       step_i,
  input  coord_t     org_row_i,
  input  coord_t     org_col_i,
  input  logic [1:0] mark_i,
  input  logic [1:0] cell_i,
  output coord_t     probe_row_o,
  output coord_t     probe_col_o,
  output logic       probe_ok_o,
  output logic       last_o,
  output logic       win_o
);

  localparam coord_t     OFF_MAX = coord_t'(WIN_LEN - 1);
  localparam coord_t     ROWS_C  = coord_t'(ROWS);
  localparam coord_t     COLS_C  = coord_t'(COLS);
  localparam logic [4:0] WIN_C   = 5'(WIN_LEN);

  logic [1:0] dir_q;
  coord_t     off_q;
  logic [4:0] run_q, run_d;
  logic       win_q;
  logic       hit;

  always_comb begin
    probe_row_o = org_row_i + dir_dr(dir_q) * off_q;
    probe_col_o = org_col_i + dir_dc(dir_q) * off_q;
    probe_ok_o  = !probe_row_o[7] && (probe_row_o < ROWS_C) &&
                  !probe_col_o[7] && (probe_col_o < COLS_C);
    hit         = probe_ok_o && (cell_i == mark_i);
    run_d       = hit ? run_q + 5'd1 : 5'd0;
    win_o       = win_q | (run_d >= WIN_C);
    last_o      = step_i && (dir_q == 2'd3) && (off_q == OFF_MAX);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni || clear_i) begin
      dir_q <= 2'd0;
      off_q <= -OFF_MAX;
      run_q <= '0;
      win_q <= 1'b0;
    end else if (step_i) begin
      win_q <= win_o;
      // Each direction starts a fresh run.
      if (off_q == OFF_MAX) begin
        off_q <= -OFF_MAX;
        dir_q <= dir_q + 2'd1;
        run_q <= '0;
      end else begin
        off_q <= off_q + 8'sd1;
        run_q <= run_d;
      end
    end
  end

endmodule

// File: rtl/mnk_game_engine.sv
// m,n,k game referee: validates moves, stores the board, detects wins/draws.
// Optional per-turn time limit enabled by defining MNK_TURN_TIMEOUT_EN.
module mnk_game_engine
  import mnk_game_pkg::*;
#(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int WIN_LEN     = 3,
  parameter int TIMEOUT_CYC = 255,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int MW = $clog2(ROWS * COLS + 1)
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          move_valid_i,
  output logic          move_ready_o,
  input  logic          move_side_i,
  input  logic [RW-1:0] move_row_i,
  input  logic [CW-1:0] move_col_i,
  output logic          move_ack_o,
  output logic          move_err_o,
  input  logic [RW-1:0] rd_row_i,
  input  logic [CW-1:0] rd_col_i,
  output logic [1:0]    rd_cell_o,
  output logic          turn_o,
  output logic [MW-1:0] move_count_o,
  output logic          game_over_o,
  output logic [1:0]    winner_o,
  output logic          timeout_o
);

  localparam logic [MW-1:0] FULL = MW'(ROWS * COLS);

  state_e                       state_q;
  logic [ROWS-1:0][COLS-1:0][1:0] cells_q;
  logic                         turn_q, ack_q, err_q;
  logic [MW-1:0]                count_q;
  logic [1:0]                   winner_q;
  logic [RW-1:0]                org_row_q;
  logic [CW-1:0]                org_col_q;

  logic       in_range, legal, xfer, accept, tmo_fire;
  logic [1:0] mark, target, probe_cell;
  coord_t     probe_row, probe_col;
  logic       probe_ok, scan_last, scan_win;

  always_comb begin
    mark      = turn_q ? CELL_CPU : CELL_PLAYER;
    in_range  = (32'(move_row_i) < ROWS) && (32'(move_col_i) < COLS);
    target    = in_range ? cells_q[move_row_i][move_col_i] : CELL_CPU;
    legal     = in_range && (target == CELL_EMPTY) && (move_side_i == turn_q);
    xfer      = move_valid_i && (state_q == S_WAIT_MOVE) && !start_i;
    accept    = xfer && legal;
    rd_cell_o = ((32'(rd_row_i) < ROWS) && (32'(rd_col_i) < COLS)) ?
                cells_q[rd_row_i][rd_col_i] : CELL_EMPTY;
    probe_cell = probe_ok ? cells_q[probe_row[RW-1:0]][probe_col[CW-1:0]] : CELL_EMPTY;
  end

  logic unused_probe;
  assign unused_probe = ^{probe_row[7:RW], probe_col[7:CW]};

  mnk_line_scanner #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_scan (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .clear_i     (start_i || accept),
    .step_i      ((state_q == S_SCAN) && !start_i),
    .org_row_i   (coord_t'(org_row_q)),
    .org_col_i   (coord_t'(org_col_q)),
    .mark_i      (mark),
    .cell_i      (probe_cell),
    .probe_row_o (probe_row),
    .probe_col_o (probe_col),
    .probe_ok_o  (probe_ok),
    .last_o      (scan_last),
    .win_o       (scan_win)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      cells_q   <= '0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      winner_q  <= CELL_EMPTY;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      org_row_q <= '0;
      org_col_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (start_i) begin
        state_q  <= S_WAIT_MOVE;
        cells_q  <= '0;
        turn_q   <= 1'b0;
        count_q  <= '0;
        winner_q <= CELL_EMPTY;
      end else begin
        case (state_q)
          S_WAIT_MOVE: begin
            if (accept) begin
              cells_q[move_row_i][move_col_i] <= mark;
              ack_q     <= 1'b1;
              count_q   <= count_q + MW'(1);
              org_row_q <= move_row_i;
              org_col_q <= move_col_i;
              state_q   <= S_SCAN;
            end else begin
              err_q <= xfer;
              if (tmo_fire) turn_q <= ~turn_q;
            end
          end
          S_SCAN: begin
            // turn_q still names the mover until the scan resolves.
            if (scan_last) begin
              if (scan_win) begin
                winner_q <= mark;
                state_q  <= S_DONE;
              end else if (count_q == FULL) begin
                state_q  <= S_DONE;
              end else begin
                turn_q   <= ~turn_q;
                state_q  <= S_WAIT_MOVE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MNK_TURN_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt_q;
  logic        tmo_q;

  assign tmo_fire = (state_q == S_WAIT_MOVE) && !start_i && !accept && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= tmo_fire;
      if ((state_q != S_WAIT_MOVE) || start_i || accept || tmo_fire) tmo_cnt_q <= '0;
      else tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
  assign timeout_o = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^16'(TIMEOUT_CYC);
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign move_ready_o = (state_q == S_WAIT_MOVE);
  assign game_over_o  = (state_q == S_DONE);
  assign move_ack_o   = ack_q;
  assign move_err_o   = err_q;
  assign turn_o       = turn_q;
  assign move_count_o = count_q;
  assign winner_o     = winner_q;

endmodule

// File: doc/mnk_game_engine.md
MNK_GAME_ENGINE -- requirements
Module: mnk_game_engine

Interface
REQ-001 SHALL have parameter ROWS, default 3, board rows (3..16).
REQ-002 SHALL have parameter COLS, default 3, board columns (3..16).
REQ-003 SHALL have parameter WIN_LEN, default 3, run length that wins (3..max(ROWS,COLS)).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, turn time limit in cycles (1..65535).
REQ-005 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port start  in  1  clears the board and begins a new game.
REQ-008 SHALL have port move_valid  in  1  move request.
REQ-009 SHALL have port move_ready  out  1  engine can accept a move.
REQ-010 SHALL have port move_side  in  1  0 = player, 1 = computer.
REQ-011 SHALL have port move_row  in  $clog2(ROWS)  target row.
REQ-012 SHALL have port move_col  in  $clog2(COLS)  target column.
REQ-013 SHALL have port move_ack  out  1  one-cycle pulse, move accepted.
REQ-014 SHALL have port move_err  out  1  one-cycle pulse, move rejected.
REQ-015 SHALL have ports rd_row / rd_col (in, row/col widths) and rd_cell (out, 2), combinational cell read.
REQ-016 SHALL have port turn  out  1  side to move next.
REQ-017 SHALL have port move_count  out  $clog2(ROWS*COLS+1)  accepted moves this game.
REQ-018 SHALL have port game_over  out  1  game finished.
REQ-019 SHALL have port winner  out  2  00 none/draw, 01 player, 10 computer.
REQ-020 SHALL have port timeout  out  1  one-cycle pulse, turn forfeited.

Function
REQ-021 SHALL encode each cell as 00 empty, 01 player, 10 computer; 11 is never stored.
REQ-022 SHALL implement FSM IDLE -> WAIT_MOVE (on start) -> SCAN (on accepted move) -> WAIT_MOVE or DONE; DONE -> WAIT_MOVE (on start).
REQ-023 SHALL assert move_ready only in WAIT_MOVE; a transfer occurs when move_valid && move_ready.
REQ-024 SHALL reject a transfer when the row/column is out of range, the cell is occupied, or move_side != turn; rejection pulses move_err the next cycle and leaves the board, turn and state unchanged.
REQ-025 SHALL, on an accepted transfer, write the cell at that edge, pulse move_ack the next cycle, increment move_count, and enter SCAN.
REQ-026 SHALL, in SCAN, walk 4 directions (row, column, diagonal, anti-diagonal) through the placed cell, offsets -(WIN_LEN-1)..+(WIN_LEN-1), one cell per cycle; run count resets on a mismatch or off-board cell.
REQ-027 SHALL fix SCAN latency at 4*(2*WIN_LEN-1) cycles regardless of an early win.
REQ-028 SHALL, on leaving SCAN, enter DONE with winner = the mover's code if any run reached WIN_LEN; otherwise enter DONE with winner = 00 if move_count == ROWS*COLS; otherwise toggle turn and return to WAIT_MOVE.
REQ-029 SHALL hold game_over = 1 exactly in DONE.
REQ-030 SHALL give start priority over move_valid in the same cycle (no ack/err); start in any state clears cells, move_count, winner, sets turn = 0 and enters WAIT_MOVE next cycle.
REQ-031 SHALL let the player (turn = 0) move first in every game.

Reset
REQ-032 SHALL, while reset = 0 at a clock edge, clear all cells, enter IDLE, and drive move_ready, move_ack, move_err, turn, move_count, game_over, winner and timeout to 0.
REQ-033 SHALL let reset override start and any SCAN in progress.

Configuration
REQ-034 SHALL, when MNK_TURN_TIMEOUT_EN is defined, count cycles in WAIT_MOVE; after TIMEOUT_CYC cycles with no accepted move, pulse timeout, toggle turn, and restart the count; the count clears on entering WAIT_MOVE.
REQ-035 SHALL, when MNK_TURN_TIMEOUT_EN is undefined, omit the counter and tie timeout to 0; the port remains present.

Structure
REQ-036 SHALL place the cell-encoding constants, the FSM state enum and the direction row/column deltas in package mnk_game_pkg.
REQ-037 SHALL implement the run walker and counter of REQ-026 as sub-module mnk_line_scanner.

Verification
REQ-038 SHALL cover: 3x3, player (0,0), computer (1,0), player (0,1), computer (1,1), player (0,2) -> five acks; game_over after 20 SCAN cycles; winner = 01.
REQ-039 SHALL cover: a move into occupied cell (1,1), then move_side = 1 on the player's turn -> move_err each time; board and turn unchanged.
REQ-040 SHALL cover: 3x3 draw sequence of 9 moves -> move_count = 9, game_over = 1, winner = 00.
REQ-041 SHALL cover: ROWS = 6, COLS = 7, WIN_LEN = 4, computer anti-diagonal (5,0),(4,1),(3,2),(2,3) -> winner = 10 after 28 SCAN cycles.
REQ-042 SHALL cover: start during SCAN, and reset = 0 in WAIT_MOVE -> board empty and turn = 0; move_count = 0 in both cases; next state is WAIT_MOVE or IDLE respectively.
REQ-043 SHALL cover, with MNK_TURN_TIMEOUT_EN defined and TIMEOUT_CYC = 10: idle for 10 cycles -> timeout pulse, turn = 1; with the macro undefined -> timeout stays 0.
